// File: rtl/max_pool2d_stream_pkg.sv
// max_pool2d_stream_pkg: pooling mode encodings, default datapath width and
// a signed/unsigned "greater than" helper shared by the pooling layers.
// No ports; imported with import max_pool2d_stream_pkg::*.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif
package max_pool2d_stream_pkg;
   localparam int INTERNAL_BITS = `INTERNAL_BITS;
   localparam bit POOL_MAX = 1'b0;
   localparam bit POOL_AVG = 1'b1;
   // a > b given both sign bits and the unsigned compare of the remaining bits
   function automatic logic greater(input logic sgn, input logic a_msb, input logic b_msb,
                                    input logic low_gt);
      return (a_msb != b_msb) ? (sgn ? b_msb : a_msb) : low_gt;
   endfunction
endpackage

// File: rtl/max_pool2d_stream_pool_line_buf.sv
// pool_line_buf: half-width line of partial pooling results, one write and one
// asynchronous read port, no reset (always written before read within a frame).
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module pool_line_buf #(
   parameter int DEPTH  = 14,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/max_pool2d_stream.sv
// max_pool2d_stream: streaming 2x2 stride-2 max/average pooling over a raster
// pixel stream with valid/ready on both sides.
// Ports: clk, rst (async, active-high), clr (sync frame restart);
//   in_valid/in_ready/in_data input pixel stream;
//   out_valid/out_ready/out_data/out_last pooled stream, out_last on frame end.
module max_pool2d_stream
   import max_pool2d_stream_pkg::*;
#(
   parameter int DATA_W = INTERNAL_BITS,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter bit SIGNED = 1'b1,
   parameter bit MODE   = POOL_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);
   localparam int AW    = DATA_W + int'(MODE);
   localparam int SW    = DATA_W + 2;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam int DEPTH = IMG_W / 2;
   localparam int LA    = DEPTH > 1 ? $clog2(DEPTH) : 1;

   if (IMG_W % 2 != 0 || IMG_H % 2 != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_geometry
      $error("max_pool2d_stream: IMG_W and IMG_H must be even and >= 2");
   end

   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   logic [AW-1:0]        h_reg, lb_rd;
   logic                 acc, col_end, row_end;
   logic [SW-1:0]        in_e, h_e, lb_e, h_sum, r_sum;
   logic signed [SW-1:0] r_signed;
   logic [DATA_W-1:0]    shr_s, shr_u, res;

   // max selects an operand, average accumulates; both work on SW-wide extended values
   function automatic logic [SW-1:0] op(input logic [SW-1:0] a, input logic [SW-1:0] b);
      return MODE ? a + b : (greater(SIGNED, a[SW-1], b[SW-1], a[SW-2:0] > b[SW-2:0]) ? a : b);
   endfunction

   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;
   assign col_end  = col == CW'(IMG_W - 1);
   assign row_end  = row == RW'(IMG_H - 1);

   assign in_e  = {{2{SIGNED && in_data[DATA_W-1]}}, in_data};
   assign h_e   = {{(SW-AW){SIGNED && h_reg[AW-1]}}, h_reg};
   assign lb_e  = {{(SW-AW){SIGNED && lb_rd[AW-1]}}, lb_rd};
   // a horizontal pair always fits in AW bits, so h_sum is already its own SW extension
   assign h_sum = op(h_e, in_e);
   assign r_sum = op(lb_e, h_sum);
   assign r_signed = r_sum;
   assign shr_s = DATA_W'(r_signed >>> 2);
   assign shr_u = DATA_W'(r_sum >> 2);
   assign res   = MODE ? (SIGNED ? shr_s : shr_u) : r_sum[DATA_W-1:0];

   pool_line_buf #(.DEPTH(DEPTH), .WIDTH(AW)) u_line_buf (
      .clk   (clk),
      .we    (acc && !clr && col[0] && !row[0]),
      .waddr (LA'(col >> 1)),
      .wdata (h_sum[AW-1:0]),
      .raddr (LA'(col >> 1)),
      .rdata (lb_rd)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         col   <= '0;
         row   <= '0;
         h_reg <= '0;
      end else if (clr) begin
         col   <= '0;
         row   <= '0;
         h_reg <= '0;
      end else if (acc) begin
         col <= col_end ? '0 : col + 1'b1;
         if (col_end) row <= row_end ? '0 : row + 1'b1;
         if (!col[0]) h_reg <= in_e[AW-1:0];
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (acc && col[0] && row[0]) begin
         out_valid <= 1'b1;
         out_data  <= res;
         out_last  <= row_end && col_end;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
endmodule

// File: tb/tb_max_pool2d_stream.sv
// tb_max_pool2d_stream: directed and randomised checks of max_pool2d_stream.
module tb_max_pool2d_stream;
   logic        clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 1;
   logic [31:0] in_data = 0;
   logic [3:0]  ir, ov, ol;
   logic [31:0] od [4];
   logic [31:0] q [4][$];
   logic        ql [4][$];
   logic        b_iv = 0, b_ir, b_ov, b_or = 1, b_ol;
   logic [31:0] b_id = 0, b_od;
   logic [31:0] bq [$];
   logic        bql [$];
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   // k: 0 max unsigned, 1 max signed, 2 avg unsigned, 3 avg signed
   for (genvar k = 0; k < 4; k++) begin : g_dut
      max_pool2d_stream #(.DATA_W(32), .IMG_W(4), .IMG_H(4), .SIGNED(k % 2 == 1), .MODE(k / 2 == 1)) u_dut (
         .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir[k]), .in_data(in_data),
         .out_valid(ov[k]), .out_ready(out_ready), .out_data(od[k]), .out_last(ol[k]));
      always @(negedge clk)
         if (ov[k] && out_ready) begin
            q[k].push_back(od[k]);
            ql[k].push_back(ol[k]);
         end
   end

   max_pool2d_stream #(.DATA_W(32), .IMG_W(28), .IMG_H(28), .SIGNED(1'b1), .MODE(1'b1)) u_big (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
      .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_last(b_ol));

   always @(negedge clk)
      if (b_ov && b_or) begin
         bq.push_back(b_od);
         bql.push_back(b_ol);
      end

   task automatic clear_q;
      for (int j = 0; j < 4; j++) begin
         q[j].delete();
         ql[j].delete();
      end
   endtask

   task automatic send(input logic [31:0] d);
      logic a = 0;
      in_valid = 1;
      in_data  = d;
      for (int i = 0; i < 50 && !a; i++) begin
         @(negedge clk);
         a = ir[0];
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      if (!a) begin
         checks++;
         errors++;
         $display("FAIL send_timeout data=%0d in_ready=%b required 1", d, a);
      end
   endtask

   task automatic send_big(input logic [31:0] d);
      logic a = 0;
      for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
         b_or = 1'($urandom_range(1, 0));
         @(posedge clk);
         #1;
      end
      b_iv = 1;
      b_id = d;
      for (int i = 0; i < 200 && !a; i++) begin
         b_or = 1'($urandom_range(1, 0));
         @(negedge clk);
         a = b_ir;
         @(posedge clk);
         #1;
      end
      b_iv = 0;
      if (!a) begin
         checks++;
         errors++;
         $display("FAIL send_big_timeout in_ready=%b required 1", a);
      end
   endtask

   function automatic longint sx(input logic [31:0] v);
      logic signed [31:0] t;
      t = v;
      return t;
   endfunction

   task automatic test_reset;
      rst = 1;
      #12;
      for (int j = 0; j < 4; j++) begin
         checks++; if (ov[j] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b required 0", j, ov[j]); end
         checks++; if (od[j] !== 32'd0) begin errors++; $display("FAIL reset_out_data[%0d] got %h required 0", j, od[j]); end
         checks++; if (ol[j] !== 1'b0) begin errors++; $display("FAIL reset_out_last[%0d] got %b required 0", j, ol[j]); end
         checks++; if (ir[j] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %b required 1", j, ir[j]); end
      end
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic test_stream;
      logic [31:0] e [4][4];
      e = '{'{5, 7, 13, 15}, '{5, 7, 13, 15}, '{2, 4, 10, 12}, '{2, 4, 10, 12}};
      clear_q();
      out_ready = 1;
      for (int i = 0; i < 5; i++) send(i);
      checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL latency_early out_valid got %b required 0", ov[0]); end
      send(5);
      checks++; if (ov[0] !== 1'b1 || od[0] !== 32'd5) begin errors++; $display("FAIL latency out_valid=%b data=%0d required 1/5", ov[0], od[0]); end
      for (int i = 6; i < 32; i++) send(i % 16);
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (q[j].size() != 8) begin errors++; $display("FAIL stream_count[%0d] got %0d required 8", j, q[j].size()); end
         else for (int n = 0; n < 8; n++) begin
            checks++;
            if (q[j][n] !== e[j][n % 4] || ql[j][n] !== (n % 4 == 3)) begin
               errors++;
               $display("FAIL stream[%0d][%0d] got %0d last=%b required %0d last=%b", j, n, q[j][n], ql[j][n], e[j][n % 4], n % 4 == 3);
            end
         end
      end
   endtask

   task automatic test_signed;
      logic [31:0] px [16];
      logic [31:0] e [4][4];
      px = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001,
             32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'h0000_0002, 32'hFFFF_FFFD,
             0, 0, 0, 0, 0, 0, 0, 0};
      e = '{'{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0}, '{32'hFFFF_FFFF, 32'h0000_0002, 0, 0},
            '{32'hFFFF_FFFD, 32'h7FFF_FFFF, 0, 0}, '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0}};
      clear_q();
      for (int i = 0; i < 16; i++) send(px[i]);
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (q[j].size() != 4) begin errors++; $display("FAIL signed_count[%0d] got %0d required 4", j, q[j].size()); end
         else for (int n = 0; n < 4; n++) begin
            checks++;
            if (q[j][n] !== e[j][n]) begin errors++; $display("FAIL signed[%0d][%0d] got %h required %h", j, n, q[j][n], e[j][n]); end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] e [4];
      e = '{5, 7, 13, 15};
      clear_q();
      out_ready = 1;
      for (int i = 0; i < 6; i++) send(i);
      out_ready = 0;
      in_valid  = 1;
      in_data   = 6;
      repeat (5) begin
         @(negedge clk);
         checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b required 0", ir[0]); end
         checks++; if (ov[0] !== 1'b1 || od[0] !== 32'd5) begin errors++; $display("FAIL bp_hold valid=%b data=%0d required 1/5", ov[0], od[0]); end
         @(posedge clk);
         #1;
      end
      out_ready = 1;
      for (int i = 6; i < 16; i++) send(i);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (q[0].size() != 4) begin errors++; $display("FAIL bp_count got %0d required 4", q[0].size()); end
      else for (int n = 0; n < 4; n++) begin
         checks++;
         if (q[0][n] !== e[n]) begin errors++; $display("FAIL bp[%0d] got %0d required %0d", n, q[0][n], e[n]); end
      end
   endtask

   task automatic test_reset_clr;
      logic [31:0] e [2][4];
      e = '{'{5, 7, 13, 15}, '{2, 4, 10, 12}};
      clear_q();
      out_ready = 1;
      for (int i = 0; i < 7; i++) send(i);
      #3 rst = 1;
      #1;
      for (int j = 0; j < 4; j += 2) begin
         checks++;
         if (ov[j] !== 1'b0 || od[j] !== 32'd0 || ol[j] !== 1'b0 || ir[j] !== 1'b1) begin
            errors++;
            $display("FAIL async_rst[%0d] valid=%b data=%0d last=%b ready=%b required 0/0/0/1", j, ov[j], od[j], ol[j], ir[j]);
         end
      end
      @(posedge clk);
      #1;
      rst = 0;
      for (int i = 0; i < 6; i++) send(i);
      checks++; if (ov[0] !== 1'b1 || od[0] !== 32'd5) begin errors++; $display("FAIL rst_restart valid=%b data=%0d required 1/5", ov[0], od[0]); end
      clr      = 1;
      in_valid = 1;
      in_data  = 99;
      @(posedge clk);
      #1;
      clr      = 0;
      in_valid = 0;
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (ov[j] !== 1'b0 || od[j] !== 32'd0) begin errors++; $display("FAIL clr[%0d] valid=%b data=%0d required 0/0", j, ov[j], od[j]); end
      end
      clear_q();
      for (int i = 0; i < 16; i++) send(i);
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
         checks++;
         if (q[j * 2].size() != 4) begin errors++; $display("FAIL after_clr_count[%0d] got %0d required 4", j * 2, q[j * 2].size()); end
         else for (int n = 0; n < 4; n++) begin
            checks++;
            if (q[j * 2][n] !== e[j][n] || ql[j * 2][n] !== (n == 3)) begin
               errors++;
               $display("FAIL after_clr[%0d][%0d] got %0d last=%b required %0d last=%b", j * 2, n, q[j * 2][n], ql[j * 2][n], e[j][n], n == 3);
            end
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] pix [28][28];
      logic [31:0] exp_q [$];
      longint      s;
      int          lasts = 0;
      bq.delete();
      bql.delete();
      for (int f = 0; f < 3; f++) begin
         for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
               pix[r][c] = $urandom;
               send_big(pix[r][c]);
            end
         for (int r = 0; r < 14; r++)
            for (int c = 0; c < 14; c++) begin
               s = sx(pix[2*r][2*c]) + sx(pix[2*r][2*c+1]) + sx(pix[2*r+1][2*c]) + sx(pix[2*r+1][2*c+1]);
               exp_q.push_back(32'(s >>> 2));
            end
      end
      b_or = 1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bq.size() != 588) begin errors++; $display("FAIL random_count got %0d required 588", bq.size()); end
      for (int n = 0; n < bq.size() && n < 588; n++) begin
         if (bql[n]) lasts++;
         checks++;
         if (bq[n] !== exp_q[n] || bql[n] !== (n % 196 == 195)) begin
            errors++;
            $display("FAIL random[%0d] got %h last=%b required %h last=%b", n, bq[n], bql[n], exp_q[n], n % 196 == 195);
         end
      end
      checks++;
      if (lasts != 3) begin errors++; $display("FAIL random_lasts got %0d required 3", lasts); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_signed();
      test_backpressure();
      test_reset_clr();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/max_pool2d_stream.md
# max_pool2d_stream

Streaming 2×2, stride-2 pooling engine that sits between a convolution layer's output stream and the next layer's input buffer in the LeNet-5 datapath. It accepts one feature-map pixel per cycle in raster order under a valid/ready handshake, keeps one half-width line of partial results, and emits one pooled pixel per 2×2 window. It supports max or average mode and signed or unsigned data. It marks the last pooled pixel of each frame.

## Interface
Parameters:
- DATA_W, 32: pixel width (`INTERNAL_BITS` by default).
- IMG_W, 28: input feature-map width; must be even, ≥2.
- IMG_H, 28: input feature-map height; must be even, ≥2.
- SIGNED, 1: 1 = two's-complement compare/add, 0 = unsigned.
- MODE, 0: 0 = max pooling, 1 = average pooling.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous frame restart; zeroes counters, discards partial window and output register.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_data  in  DATA_W  input pixel.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts pooled pixel.
- out_data  out  DATA_W  pooled pixel.
- out_last  out  1  qualifies out_data as the final pixel of the frame.

## Operation
- A pixel is accepted on cycles with in_valid && in_ready. Only accepted pixels advance state.
- col (0..IMG_W-1) and row (0..IMG_H-1) counters advance per accepted pixel. col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1), both wrap to 0 and a new frame begins with no idle cycle.
- Even col: the pixel is stored in h_reg.
- Odd col: h = op(h_reg, in_data).
  - Even row: h is written to line buffer entry col>>1.
  - Odd row: result = op(linebuf[col>>1], h) is loaded into the output register.
- op in max mode: max under SIGNED; on ties either operand may be selected.
- op in average mode: a sum. h_reg and linebuf hold DATA_W+1 bits and the 4-pixel sum holds DATA_W+2 bits, sign- or zero-extended per SIGNED. The result is sum >>> 2 (arithmetic when SIGNED, i.e. floor), truncated to DATA_W. No rounding, no saturation.
- out_last = 1 when the output is produced by the pixel at (IMG_H-1, IMG_W-1).
- in_ready = !out_valid || out_ready. Input is stalled only while an unconsumed output is pending.
- Line buffer depth is IMG_W/2. It is never read before it is written within a frame, so its contents need no reset.
- Odd IMG_W or IMG_H is an elaboration-time error.

## Timing
- Reset (rst high, asynchronous): out_valid=0, out_data=0, out_last=0, col=0, row=0, h_reg=0. in_ready=1 after reset.
- Latency: out_valid rises the cycle after the window's bottom-right pixel is accepted.
- out_valid && !out_ready: out_data and out_last are held stable and in_ready=0.
- out_ready and a new result in the same cycle: the output register is overwritten and out_valid stays 1.
- Throughput: 1 input pixel per cycle sustained when out_ready=1. Output is 1 pixel per 4 inputs, bursting on odd rows.
- clr has priority over an accept in the same cycle; that pixel is dropped. After clr, out_valid=0 and the next accepted pixel is (0,0).
- rst mid-frame: all of the above reset values apply immediately. The next frame starts at (0,0).

## Structure
- Shared package: pooling mode encodings (POOL_MAX=0, POOL_AVG=1), the default DATA_W tied to `INTERNAL_BITS`, and a signed/unsigned compare function used by the pooling layers.
- Sub-module pool_line_buf: single-port-write / single-port-read array, depth IMG_W/2, width DATA_W+MODE, no reset. It maps to distributed RAM or a register array.
- Top level contains the counters, h_reg, op datapath, output register and handshake.

## Test plan
- Max, unsigned, IMG_W=IMG_H=4, pixels 0..15 streamed back-to-back with out_ready=1 -> outputs 5, 7, 13, 15; out_last only on 15; first out_valid the cycle after pixel 5 is accepted.
- Average, same stream -> 2, 4, 10, 12; then a second frame with no gap -> identical sequence.
- Signed average, a window of -1, -2, -5, -3 -> -3. Signed max on the same window -> -1. The same bit patterns with SIGNED=0 -> max = 0xFFFF_FFFF.
- Backpressure: out_ready=0 for 5 cycles while output 5 is pending -> in_ready=0, out_data holds 5, no pixels lost; the resumed stream still yields 7, 13, 15.
- Random in_valid gaps (≈50%) and random out_ready over three 28×28 frames -> output matches the reference model; exactly 196 outputs and 1 out_last per frame.
- rst asserted asynchronously after pixel 6, then clr mid-frame on the next frame -> outputs go to reset values; the next full frame pools correctly from (0,0).
